// File: rtl/band_corr_packer.sv
// Double-buffered frame packer for the band DOA correlator: collects BANDS (r11,r22,r12)
// triples per frame and streams them out as sign-extended ready/valid words.
module band_corr_packer #(
   parameter int BANDS      = 4,
   parameter int DIN_WIDTH  = 32,
   parameter int DOUT_WIDTH = 32,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic signed [DIN_WIDTH-1:0] r11,
   input  logic signed [DIN_WIDTH-1:0] r22,
   input  logic signed [DIN_WIDTH-1:0] r12,
   input  logic                        din_valid,
   input  logic [$clog2(BANDS)-1:0]    band_number,
   output logic [DOUT_WIDTH-1:0]       dout,
   output logic                        dout_valid,
   input  logic                        dout_ready,
   output logic                        dout_last,
   output logic [CNT_WIDTH-1:0]        frame_count,
   output logic [CNT_WIDTH-1:0]        drop_count,
   output logic                        overflow
);
   localparam int BW = $clog2(BANDS);

   typedef enum logic {IDLE, SEND} state_t;

   // [bank][band][component], component 0=r11, 1=r22, 2=r12
   logic [1:0][BANDS-1:0][2:0][DIN_WIDTH-1:0] mem;
   logic [1:0]    full;
   logic          fill_bank, drain_bank, dropping;
   logic [BW-1:0] exp_b, wb;
   logic [1:0]    wc;
   state_t        state, state_nx;

   logic          xfer, last_word, free_en, fill_blocked;
   logic          wr_en, fill_done, drop_inc, ovf_set, dropping_nx;
   logic [BW-1:0] wr_slot, exp_nx;
   logic          pend_cur, pend_other;
   logic signed [DIN_WIDTH-1:0] word_s;

   assign dout_valid = (state == SEND);
   assign xfer       = dout_valid && dout_ready;
   assign last_word  = (wb == BW'(BANDS-1)) && (wc == 2'd2);
   assign free_en    = xfer && last_word;
   // A bank emptied this cycle can be refilled in the same cycle.
   assign fill_blocked = full[fill_bank] && !(free_en && (drain_bank == fill_bank));

   always_comb begin
      wr_en       = 1'b0;
      wr_slot     = exp_b;
      exp_nx      = exp_b;
      fill_done   = 1'b0;
      drop_inc    = 1'b0;
      ovf_set     = 1'b0;
      dropping_nx = dropping;
      if (din_valid) begin
         if (dropping) begin
            if (band_number == '0) begin
               if (!fill_blocked) begin
                  wr_en       = 1'b1;
                  wr_slot     = '0;
                  exp_nx      = BW'(1);
                  dropping_nx = 1'b0;
               end else begin
                  drop_inc = 1'b1;
               end
            end
         end else if ((exp_b == '0) && fill_blocked) begin
            dropping_nx = 1'b1;
            ovf_set     = 1'b1;
            drop_inc    = 1'b1;
         end else if (band_number == exp_b) begin
            wr_en = 1'b1;
            if (exp_b == BW'(BANDS-1)) begin
               fill_done = 1'b1;
               exp_nx    = '0;
            end else begin
               exp_nx = exp_b + BW'(1);
            end
         end else begin
            // Sequence error: a band 0 restarts the frame, anything else resyncs.
            drop_inc = 1'b1;
            if (band_number == '0) begin
               wr_en   = 1'b1;
               wr_slot = '0;
               exp_nx  = BW'(1);
            end else begin
               exp_nx = '0;
            end
         end
      end
   end

   assign pend_cur   = full[drain_bank]  || (fill_done && (fill_bank == drain_bank));
   assign pend_other = full[~drain_bank] || (fill_done && (fill_bank != drain_bank));

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (pend_cur) state_nx = SEND;
         SEND: if (free_en && !pend_other) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         full        <= '0;
         fill_bank   <= 1'b0;
         drain_bank  <= 1'b0;
         dropping    <= 1'b0;
         exp_b       <= '0;
         wb          <= '0;
         wc          <= '0;
         frame_count <= '0;
         drop_count  <= '0;
         overflow    <= 1'b0;
      end else begin
         state    <= state_nx;
         exp_b    <= exp_nx;
         dropping <= dropping_nx;
         if (free_en) begin
            full[drain_bank] <= 1'b0;
            drain_bank       <= ~drain_bank;
            frame_count      <= frame_count + CNT_WIDTH'(1);
         end
         if (fill_done) begin
            full[fill_bank] <= 1'b1;
            fill_bank       <= ~fill_bank;
         end
         if (xfer) begin
            if (last_word) begin
               wb <= '0;
               wc <= '0;
            end else if (wc == 2'd2) begin
               wc <= '0;
               wb <= wb + BW'(1);
            end else begin
               wc <= wc + 2'd1;
            end
         end
         if (drop_inc) drop_count <= drop_count + CNT_WIDTH'(1);
         if (ovf_set)  overflow   <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en && !rst) mem[fill_bank][wr_slot] <= {r12, r22, r11};
   end

   assign word_s    = mem[drain_bank][wb][wc];
   assign dout      = dout_valid ? DOUT_WIDTH'(word_s) : '0;
   assign dout_last = dout_valid && last_word;
endmodule

// File: tb/tb_band_corr_packer.sv
// Directed bench for band_corr_packer: frame order, backpressure, double buffering,
// overflow, sequence errors and mid-drain reset.
module tb_band_corr_packer;
   localparam int BANDS = 4, DIN_W = 32, DOUT_W = 40, CNT_W = 16;
   localparam int NW = 3 * BANDS;

   logic clk = 1'b0, rst = 1'b1;
   logic signed [DIN_W-1:0] r11 = '0, r22 = '0, r12 = '0;
   logic din_valid = 1'b0, dout_ready = 1'b0;
   logic [$clog2(BANDS)-1:0] band_number = '0;
   logic [DOUT_W-1:0] dout;
   logic dout_valid, dout_last, overflow;
   logic [CNT_W-1:0] frame_count, drop_count;

   int n_checks = 0, n_fail = 0;

   band_corr_packer #(.BANDS(BANDS), .DIN_WIDTH(DIN_W), .DOUT_WIDTH(DOUT_W), .CNT_WIDTH(CNT_W)) dut (
      .clk(clk), .rst(rst), .r11(r11), .r22(r22), .r12(r12), .din_valid(din_valid),
      .band_number(band_number), .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
      .dout_last(dout_last), .frame_count(frame_count), .drop_count(drop_count), .overflow(overflow));

   always #5 clk = ~clk;

   // Transfer capture and stall-stability monitor, sampled on the falling edge.
   logic [DOUT_W-1:0] got_d[$];
   bit got_l[$];
   int got_c[$];
   int cyc = 0, stall_err = 0;
   logic prev_stall = 1'b0, prev_l = 1'b0;
   logic [DOUT_W-1:0] prev_d = '0;

   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (prev_stall && !rst && (dout_valid !== 1'b1 || dout !== prev_d || dout_last !== prev_l))
         stall_err <= stall_err + 1;
      prev_stall <= dout_valid && !dout_ready && !rst;
      prev_d <= dout;
      prev_l <= dout_last;
      if (dout_valid === 1'b1 && dout_ready === 1'b1) begin
         got_d.push_back(dout);
         got_l.push_back(dout_last);
         got_c.push_back(cyc);
      end
   end

   function automatic logic signed [DOUT_W-1:0] exp_word(input int base, input int k);
      int v;
      v = k / 3 + base;
      case (k % 3)
         0: return DOUT_W'(v);
         1: return DOUT_W'(10 * v);
         default: return DOUT_W'(-v);
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      din_valid = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      got_d.delete();
      got_l.delete();
      got_c.delete();
      stall_err = 0;
   endtask

   task automatic send_band(input int b, input int base);
      band_number = b[$clog2(BANDS)-1:0];
      r11 = DIN_W'(b + base);
      r22 = DIN_W'(10 * (b + base));
      r12 = DIN_W'(-(b + base));
      din_valid = 1'b1;
      tick();
   endtask

   task automatic send_frame(input int base);
      for (int b = 0; b < BANDS; b++) send_band(b, base);
      din_valid = 1'b0;
   endtask

   task automatic wait_words(input int n, input int budget);
      int c;
      c = 0;
      while (got_d.size() < n && c < budget) begin
         tick();
         c++;
      end
      n_checks++;
      if (got_d.size() < n) begin
         n_fail++;
         $display("FAIL wait_words: got %0d words, required %0d", got_d.size(), n);
      end
   endtask

   task automatic test_reset();
      apply_reset();
      n_checks++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: %b vs 0", dout_valid); end
      n_checks++; if (dout !== '0) begin n_fail++; $display("FAIL reset_dout: %h vs 0", dout); end
      n_checks++; if (dout_last !== 1'b0) begin n_fail++; $display("FAIL reset_last: %b vs 0", dout_last); end
      n_checks++; if (frame_count !== '0 || drop_count !== '0) begin n_fail++; $display("FAIL reset_counts: %0d %0d vs 0 0", frame_count, drop_count); end
      n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: %b vs 0", overflow); end
   endtask

   task automatic test_basic();
      logic signed [DOUT_W-1:0] exp_tab [NW];
      exp_tab = '{1, 10, -1, 2, 20, -2, 3, 30, -3, 4, 40, -4};
      apply_reset();
      dout_ready = 1'b1;
      send_frame(1);
      n_checks++; if (dout_valid !== 1'b1) begin n_fail++; $display("FAIL basic_latency: valid %b vs 1", dout_valid); end
      n_checks++; if (dout !== exp_tab[0]) begin n_fail++; $display("FAIL basic_first: %h vs %h", dout, exp_tab[0]); end
      wait_words(NW, 40);
      tick();
      n_checks++; if (got_d.size() != NW) begin n_fail++; $display("FAIL basic_count: %0d vs %0d", got_d.size(), NW); end
      for (int i = 0; i < NW && i < got_d.size(); i++) begin
         n_checks++;
         if (got_d[i] !== exp_tab[i] || got_l[i] !== (i == NW - 1)) begin
            n_fail++;
            $display("FAIL basic_word%0d: %h/%b vs %h/%b", i, got_d[i], got_l[i], exp_tab[i], i == NW - 1);
         end
      end
      n_checks++; if (frame_count !== 16'd1) begin n_fail++; $display("FAIL basic_frame_count: %0d vs 1", frame_count); end
      n_checks++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL basic_idle: valid %b vs 0", dout_valid); end
   endtask

   task automatic test_backpressure();
      int c;
      apply_reset();
      dout_ready = 1'b0;
      send_frame(1);
      c = 0;
      while (got_d.size() < NW && c < 100) begin
         dout_ready = (c % 3 == 0);
         tick();
         c++;
      end
      dout_ready = 1'b1;
      tick();
      n_checks++; if (got_d.size() != NW) begin n_fail++; $display("FAIL bp_count: %0d vs %0d", got_d.size(), NW); end
      for (int i = 0; i < NW && i < got_d.size(); i++) begin
         n_checks++;
         if (got_d[i] !== exp_word(1, i) || got_l[i] !== (i == NW - 1)) begin
            n_fail++;
            $display("FAIL bp_word%0d: %h/%b vs %h/%b", i, got_d[i], got_l[i], exp_word(1, i), i == NW - 1);
         end
      end
      n_checks++; if (stall_err != 0) begin n_fail++; $display("FAIL bp_stable: %0d unstable stalls vs 0", stall_err); end
      n_checks++; if (frame_count !== 16'd1) begin n_fail++; $display("FAIL bp_frame_count: %0d vs 1", frame_count); end
   endtask

   task automatic test_overflow();
      apply_reset();
      dout_ready = 1'b0;
      send_frame(1);
      send_frame(5);
      send_frame(9);
      tick();
      n_checks++; if (drop_count !== 16'd1) begin n_fail++; $display("FAIL ovf_drop: %0d vs 1", drop_count); end
      n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: %b vs 1", overflow); end
      n_checks++; if (frame_count !== 16'd0 || dout_valid !== 1'b1) begin n_fail++; $display("FAIL ovf_hold: fc %0d valid %b vs 0 1", frame_count, dout_valid); end
      dout_ready = 1'b1;
      wait_words(2 * NW, 60);
      tick();
      n_checks++; if (got_d.size() != 2 * NW) begin n_fail++; $display("FAIL ovf_count: %0d vs %0d", got_d.size(), 2 * NW); end
      for (int i = 0; i < 2 * NW && i < got_d.size(); i++) begin
         n_checks++;
         if (got_d[i] !== exp_word(i < NW ? 1 : 5, i % NW) || got_l[i] !== (i % NW == NW - 1)) begin
            n_fail++;
            $display("FAIL ovf_word%0d: %h/%b vs %h/%b", i, got_d[i], got_l[i], exp_word(i < NW ? 1 : 5, i % NW), i % NW == NW - 1);
         end
      end
      if (got_c.size() > NW) begin
         n_checks++;
         if (got_c[NW] != got_c[NW - 1] + 1) begin n_fail++; $display("FAIL ovf_no_bubble: gap %0d vs 1", got_c[NW] - got_c[NW - 1]); end
      end
      n_checks++; if (frame_count !== 16'd2) begin n_fail++; $display("FAIL ovf_frame_count: %0d vs 2", frame_count); end
      n_checks++; if (stall_err != 0) begin n_fail++; $display("FAIL ovf_stable: %0d unstable stalls vs 0", stall_err); end
   endtask

   task automatic test_seq_error();
      apply_reset();
      dout_ready = 1'b1;
      send_band(0, 1);
      send_band(1, 1);
      send_band(3, 1);
      din_valid = 1'b0;
      tick();
      n_checks++; if (drop_count !== 16'd1) begin n_fail++; $display("FAIL seq_drop: %0d vs 1", drop_count); end
      n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL seq_overflow: %b vs 0", overflow); end
      n_checks++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL seq_no_output: valid %b vs 0", dout_valid); end
      send_frame(20);
      wait_words(NW, 40);
      tick();
      n_checks++; if (got_d.size() != NW) begin n_fail++; $display("FAIL seq_count: %0d vs %0d", got_d.size(), NW); end
      for (int i = 0; i < NW && i < got_d.size(); i++) begin
         n_checks++;
         if (got_d[i] !== exp_word(20, i)) begin n_fail++; $display("FAIL seq_word%0d: %h vs %h", i, got_d[i], exp_word(20, i)); end
      end
      n_checks++; if (frame_count !== 16'd1 || drop_count !== 16'd1) begin n_fail++; $display("FAIL seq_counts: %0d %0d vs 1 1", frame_count, drop_count); end
   endtask

   task automatic test_restart();
      apply_reset();
      dout_ready = 1'b1;
      send_band(0, 50);
      send_band(1, 50);
      send_frame(30);
      wait_words(NW, 40);
      tick();
      n_checks++; if (drop_count !== 16'd1) begin n_fail++; $display("FAIL restart_drop: %0d vs 1", drop_count); end
      n_checks++; if (got_d.size() != NW) begin n_fail++; $display("FAIL restart_count: %0d vs %0d", got_d.size(), NW); end
      for (int i = 0; i < NW && i < got_d.size(); i++) begin
         n_checks++;
         if (got_d[i] !== exp_word(30, i)) begin n_fail++; $display("FAIL restart_word%0d: %h vs %h", i, got_d[i], exp_word(30, i)); end
      end
      n_checks++; if (frame_count !== 16'd1) begin n_fail++; $display("FAIL restart_frame_count: %0d vs 1", frame_count); end
   endtask

   task automatic test_reset_mid_drain();
      apply_reset();
      dout_ready = 1'b1;
      send_frame(1);
      wait_words(4, 20);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_checks++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid: %b vs 0", dout_valid); end
      n_checks++; if (frame_count !== '0 || drop_count !== '0 || overflow !== 1'b0) begin n_fail++; $display("FAIL mid_counts: %0d %0d %b vs 0 0 0", frame_count, drop_count, overflow); end
      tick();
      n_checks++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL mid_stays_idle: %b vs 0", dout_valid); end
      got_d.delete();
      got_l.delete();
      got_c.delete();
      send_frame(1);
      wait_words(NW, 40);
      tick();
      n_checks++; if (got_d.size() != NW) begin n_fail++; $display("FAIL mid_count: %0d vs %0d", got_d.size(), NW); end
      for (int i = 0; i < NW && i < got_d.size(); i++) begin
         n_checks++;
         if (got_d[i] !== exp_word(1, i) || got_l[i] !== (i == NW - 1)) begin
            n_fail++;
            $display("FAIL mid_word%0d: %h/%b vs %h/%b", i, got_d[i], got_l[i], exp_word(1, i), i == NW - 1);
         end
      end
      n_checks++; if (frame_count !== 16'd1) begin n_fail++; $display("FAIL mid_frame_count: %0d vs 1", frame_count); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_overflow();
      test_seq_error();
      test_restart();
      test_reset_mid_drain();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
